parity_framer: RTL and testbench

PARITY_FRAMER -- requirements
Module: parity_framer

---
 rtl/parity_pkg.sv | 16 +
 rtl/parity_lane.sv | 71 +++++++
 rtl/parity_framer.sv | 124 ++++++++++++
 tb/tb_parity_framer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared state encoding, mode constants and parity helper for the parity framer.
package parity_pkg;

    typedef enum logic {
        S_DATA = 1'b0,
        S_PAR  = 1'b1
    } state_e;

    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_CHK = 1'b1;

    function automatic logic par_of(input logic acc, input logic odd);
        return acc ^ odd;
    endfunction

endpackage

// File: rtl/parity_lane.sv
// One serial parity lane: running accumulator, visible parity, frame result and check error.
module parity_lane
    import parity_pkg::*;
#(
    parameter logic ODD_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic x,
    input  logic clr,
    input  logic acc_en,
    input  logic gen_done,
    input  logic chk_done,
    output logic z,
    output logic p,
    output logic err
);

    logic acc_q, acc_d;
    logic z_q, z_d;
    logic p_q, p_d;
    logic err_q, err_d;

    // Lane next-state: z shows the parity including the last accepted bit, even when acc is cleared
    always_comb begin
        acc_d = acc_q;
        z_d   = z_q;
        p_d   = p_q;
        err_d = err_q;
        if (clr) begin
            acc_d = 1'b0;
            z_d   = ODD_BIT;
        end else if (acc_en) begin
            acc_d = acc_q ^ x;
            z_d   = par_of(acc_q ^ x, ODD_BIT);
        end else if (gen_done) begin
            acc_d = 1'b0;
            z_d   = par_of(acc_q ^ x, ODD_BIT);
            p_d   = par_of(acc_q ^ x, ODD_BIT);
            err_d = 1'b0;
        end else if (chk_done) begin
            acc_d = 1'b0;
            z_d   = ODD_BIT;
            p_d   = x;
            err_d = x ^ par_of(acc_q, ODD_BIT);
        end else begin
            acc_d = acc_q;
            z_d   = z_q;
        end
    end

    // Lane registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 1'b0;
            z_q   <= ODD_BIT;
            p_q   <= 1'b0;
            err_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            z_q   <= z_d;
            p_q   <= p_d;
            err_q <= err_d;
        end
    end

    assign z   = z_q;
    assign p   = p_q;
    assign err = err_q;

endmodule

// File: rtl/parity_framer.sv
// Multi-lane serial parity framer: shared frame FSM and bit counter driving one parity_lane per channel.
module parity_framer
    import parity_pkg::*;
#(
    parameter int N_CH      = 1,
    parameter int FRAME_LEN = 8,
    parameter int ODD       = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] x,
    input  logic            x_valid,
    input  logic            mode,
    input  logic            clear,
    output logic [N_CH-1:0] z,
    output logic            p_valid,
    output logic [N_CH-1:0] p,
    output logic [N_CH-1:0] err
);

    localparam int       CW      = $clog2(FRAME_LEN + 1);
    localparam logic     ODD_BIT = (ODD != 0) ? 1'b1 : 1'b0;
    localparam [CW-1:0]  LAST    = CW'(FRAME_LEN - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mode_q, mode_d;
    logic          p_valid_q, p_valid_d;
    logic          eff_mode_s;
    logic          lane_clr_s, acc_en_s, gen_done_s, chk_done_s;

    // Frame FSM: mode is taken from the port only at the start of a frame
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        p_valid_d   = 1'b0;
        lane_clr_s  = 1'b0;
        acc_en_s    = 1'b0;
        gen_done_s  = 1'b0;
        chk_done_s  = 1'b0;
        eff_mode_s  = mode_q;
        if (clear) begin
            state_d    = S_DATA;
            cnt_d      = '0;
            lane_clr_s = 1'b1;
        end else begin
            case (state_q)
                S_DATA: begin
                    eff_mode_s = (cnt_q == '0) ? mode : mode_q;
                    mode_d     = eff_mode_s;
                    if (x_valid) begin
                        if (cnt_q == LAST) begin
                            if (eff_mode_s == MODE_GEN) begin
                                gen_done_s = 1'b1;
                                p_valid_d  = 1'b1;
                                cnt_d      = '0;
                            end else begin
                                acc_en_s = 1'b1;
                                cnt_d    = cnt_q + CW'(1);
                                state_d  = S_PAR;
                            end
                        end else begin
                            acc_en_s = 1'b1;
                            cnt_d    = cnt_q + CW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                S_PAR: begin
                    if (x_valid) begin
                        chk_done_s = 1'b1;
                        p_valid_d  = 1'b1;
                        cnt_d      = '0;
                        state_d    = S_DATA;
                    end else begin
                        state_d = S_PAR;
                    end
                end
                default: begin
                    state_d    = S_DATA;
                    cnt_d      = '0;
                    lane_clr_s = 1'b1;
                end
            endcase
        end
    end

    // Shared FSM, counter, mode and strobe registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_DATA;
            cnt_q     <= '0;
            mode_q    <= MODE_GEN;
            p_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            p_valid_q <= p_valid_d;
        end
    end

    assign p_valid = p_valid_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_lane
        parity_lane #(
            .ODD_BIT(ODD_BIT)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .x       (x[g]),
            .clr     (lane_clr_s),
            .acc_en  (acc_en_s),
            .gen_done(gen_done_s),
            .chk_done(chk_done_s),
            .z       (z[g]),
            .p       (p[g]),
            .err     (err[g])
        );
    end

endmodule

// File: tb/tb_parity_framer.sv
// Directed bench: 2-lane even framer (A), 1-lane odd framer (B) sharing A's lane 0, 1-bit-frame framer (C).
module tb_parity_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, xv, md, clr;
    logic [1:0] xa, za, pa, erra;
    logic       pva;
    logic [0:0] xb, zb, pb, errb;
    logic       pvb;
    logic [0:0] xc, zc, pc, errc;
    logic       xvc, mdc, clrc, pvc;

    assign xb = xa[0:0];

    parity_framer #(.N_CH(2), .FRAME_LEN(4), .ODD(0)) u_a (
        .clk(clk), .rst_n(rst_n), .x(xa), .x_valid(xv), .mode(md), .clear(clr),
        .z(za), .p_valid(pva), .p(pa), .err(erra));

    parity_framer #(.N_CH(1), .FRAME_LEN(4), .ODD(1)) u_b (
        .clk(clk), .rst_n(rst_n), .x(xb), .x_valid(xv), .mode(md), .clear(clr),
        .z(zb), .p_valid(pvb), .p(pb), .err(errb));

    parity_framer #(.N_CH(1), .FRAME_LEN(1), .ODD(0)) u_c (
        .clk(clk), .rst_n(rst_n), .x(xc), .x_valid(xvc), .mode(mdc), .clear(clrc),
        .z(zc), .p_valid(pvc), .p(pc), .err(errc));

    typedef struct {
        logic       xv;
        logic [1:0] x;
        logic       md;
        logic       clr;
        logic [1:0] z;
        logic       pv;
        logic [1:0] p;
        logic [1:0] err;
        logic       zb;
        logic       pb;
        logic       errb;
    } vec_t;

    vec_t tbl [28];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [1:0] xi, input logic m, input logic c);
        @(negedge clk);
        xv = v; xa = xi; md = m; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic stepc(input logic v, input logic xi, input logic m);
        @(negedge clk);
        xvc = v; xc = xi; mdc = m;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; xv = 1'b0; xa = 2'b00; md = 1'b0; clr = 1'b0;
        xvc = 1'b0; xc = 1'b0; mdc = 1'b0; clrc = 1'b0;

        //          xv    x      md    clr  | z      pv    p      err   | zb    pb    errb
        tbl[0]  = '{1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 2'b11, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 2'b11, 1'b0, 1'b0, 2'b01, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 2'b11, 1'b0, 1'b0, 2'b10, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 2'b01, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 2'b01, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 2'b01, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 2'b01, 1'b1, 1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 1'b1, 1'b1, 1'b1};
        tbl[15] = '{1'b1, 2'b11, 1'b1, 1'b0, 2'b11, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b1};
        tbl[16] = '{1'b1, 2'b10, 1'b1, 1'b0, 2'b01, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b1};
        tbl[17] = '{1'b1, 2'b11, 1'b1, 1'b0, 2'b10, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b1};
        tbl[18] = '{1'b1, 2'b01, 1'b1, 1'b0, 2'b11, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b1};
        tbl[19] = '{1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0};
        tbl[20] = '{1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0};
        tbl[21] = '{1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0};
        tbl[22] = '{1'b1, 2'b11, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0};
        tbl[23] = '{1'b1, 2'b11, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0};
        tbl[24] = '{1'b1, 2'b10, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0};
        tbl[25] = '{1'b1, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0};
        tbl[26] = '{1'b1, 2'b00, 1'b1, 1'b0, 2'b01, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[27] = '{1'b0, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_za",   8'(za),   8'h00);
        chk("rst_zb",   8'(zb),   8'h01);
        chk("rst_pva",  8'(pva),  8'h00);
        chk("rst_pa",   8'(pa),   8'h00);
        chk("rst_erra", 8'(erra), 8'h00);
        chk("rst_zc",   8'(zc),   8'h00);
        rst_n = 1'b1;

        for (int i = 0; i < 28; i++) begin
            step(tbl[i].xv, tbl[i].x, tbl[i].md, tbl[i].clr);
            chk($sformatf("v%0d_z", i),    8'(za),   8'(tbl[i].z));
            chk($sformatf("v%0d_pv", i),   8'(pva),  8'(tbl[i].pv));
            chk($sformatf("v%0d_p", i),    8'(pa),   8'(tbl[i].p));
            chk($sformatf("v%0d_err", i),  8'(erra), 8'(tbl[i].err));
            chk($sformatf("v%0d_zb", i),   8'(zb),   8'(tbl[i].zb));
            chk($sformatf("v%0d_pvb", i),  8'(pvb),  8'(tbl[i].pv));
            chk($sformatf("v%0d_pb", i),   8'(pb),   8'(tbl[i].pb));
            chk($sformatf("v%0d_errb", i), 8'(errb), 8'(tbl[i].errb));
        end

        // reset in the middle of a frame: partial frame discarded
        step(1'b1, 2'b01, 1'b0, 1'b0);
        step(1'b1, 2'b00, 1'b0, 1'b0);
        chk("mid_za", 8'(za), 8'h01);
        chk("mid_zb", 8'(zb), 8'h00);
        @(negedge clk);
        xv = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_za",   8'(za),   8'h00);
        chk("arst_zb",   8'(zb),   8'h01);
        chk("arst_pva",  8'(pva),  8'h00);
        chk("arst_pa",   8'(pa),   8'h00);
        chk("arst_erra", 8'(erra), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 2'b11, 1'b0, 1'b0);
        chk("post_pv1", 8'(pva), 8'h00);
        step(1'b1, 2'b00, 1'b0, 1'b0);
        chk("post_pv2", 8'(pva), 8'h00);
        step(1'b1, 2'b00, 1'b0, 1'b0);
        chk("post_pv3", 8'(pva), 8'h00);
        step(1'b1, 2'b00, 1'b0, 1'b0);
        chk("post_pv4", 8'(pva), 8'h01);
        chk("post_p",   8'(pa),  8'h03);
        chk("post_pb",  8'(pb),  8'h00);
        step(1'b0, 2'b00, 1'b0, 1'b0);
        chk("post_pv5", 8'(pva), 8'h00);

        // single-bit frames: generate strobes every bit, check every two bits
        stepc(1'b1, 1'b1, 1'b0);
        chk("c1_pv", 8'(pvc), 8'h01);
        chk("c1_p",  8'(pc),  8'h01);
        chk("c1_z",  8'(zc),  8'h01);
        stepc(1'b1, 1'b0, 1'b0);
        chk("c2_pv", 8'(pvc), 8'h01);
        chk("c2_p",  8'(pc),  8'h00);
        stepc(1'b1, 1'b1, 1'b1);
        chk("c3_pv", 8'(pvc), 8'h00);
        chk("c3_z",  8'(zc),  8'h01);
        stepc(1'b1, 1'b0, 1'b1);
        chk("c4_pv",  8'(pvc),  8'h01);
        chk("c4_p",   8'(pc),   8'h00);
        chk("c4_err", 8'(errc), 8'h01);
        stepc(1'b1, 1'b0, 1'b1);
        chk("c5_pv",  8'(pvc),  8'h00);
        chk("c5_err", 8'(errc), 8'h01);
        stepc(1'b1, 1'b0, 1'b1);
        chk("c6_pv",  8'(pvc),  8'h01);
        chk("c6_err", 8'(errc), 8'h00);
        stepc(1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
